scratchpad_stream_reader: RTL and testbench

Read-side DMA engine for the tensorcore scratchpad: on a start command it issues `len` sequential reads (pointer 0..len-1, relative to the scratchpad's base address) and emits the returned words as an AXI-Stream master with `tlast` on the final beat. It absorbs the scratchpad's fixed 1-cycle read latency and downstream backpressure through a small internal FIFO. It sits between the scratchpad's DMA read port and the outbound stream toward the host DMA.

---
 rtl/tpu_dma_pkg.sv | 23 ++
 rtl/stream_fifo.sv | 53 +++++
 rtl/scratchpad_stream_reader.sv | 101 ++++++++++
 tb/tb_scratchpad_stream_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_dma_pkg.sv
// Shared types and constants for the tensorcore DMA engines.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package tpu_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dma_state_t;

  // Four entries cover the read round trip (issue, capture, present) at one beat per cycle.
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  localparam int AXIS_DATA_WIDTH = 32;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic                       last;
  } axis_beat_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with head-of-queue visible combinationally.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage write; entries are only read after being written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/scratchpad_stream_reader.sv
// Streams len scratchpad words (pointer 0..len-1) out as AXI-Stream with tlast on the final beat.
// Latency: start in cycle 0, first read in cycle 1, first beat in cycle 3, done one cycle after tlast.
// Backpressure: tready stalls the FIFO; reads are credit-limited so in-flight data always fits.
module scratchpad_stream_reader
  import tpu_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [15:0]           rd_pointer,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  // The pointer port is 16 bits wide and the scratchpad does the base addition and wrap.
  if (ADDR_WIDTH < 1 || LEN_WIDTH > 16 || LEN_WIDTH < 1) begin : g_param_check
    $error("scratchpad_stream_reader: unsupported ADDR_WIDTH/LEN_WIDTH");
  end

  dma_state_t            state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  sent;
  logic                  inflight;
  logic [FIFO_CW-1:0]    fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [FIFO_CW:0]      credit_used;
  logic                  beat_fire;

  // Entries held plus the read still in flight must leave room before another read is issued.
  assign credit_used = {1'b0, fifo_count} + {{FIFO_CW{1'b0}}, inflight};

  assign rd_en      = (state == ST_RUN) && (issued < len_q)
                    && (credit_used < (FIFO_CW + 1)'(FIFO_DEPTH));
  assign rd_pointer = 16'(issued);

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head;
  assign m_axis_tlast  = m_axis_tvalid && (sent == len_q - LEN_WIDTH'(1));
  assign beat_fire     = m_axis_tvalid && m_axis_tready;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (rd_data),
    .pop       (beat_fire),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Transfer FSM with read-issue and beat counters; read data is captured the cycle after rd_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q  <= len;
            issued <= '0;
            sent   <= '0;
            state  <= (len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_en)     issued <= issued + LEN_WIDTH'(1);
          if (beat_fire) sent   <= sent + LEN_WIDTH'(1);
          if (beat_fire && m_axis_tlast) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_stream_reader.sv
module tb_scratchpad_stream_reader;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   len = '0;
  logic          busy, done, rd_en;
  logic [15:0]   rd_pointer;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;

  always #5 clk = ~clk;

  scratchpad_stream_reader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_pointer    (rd_pointer),
    .rd_data       (rd_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  // Scratchpad model: word addressed by pointer, data valid only the cycle after rd_en.
  logic [DW-1:0] mem [65536];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_pointer] : $urandom;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Scoreboard: {last, data} per expected beat, pushed when a transfer is commanded.
  logic [DW:0] exp_q[$];

  // Random tready when rdy_mode is set; changes away from the sampling edge.
  bit rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    m_axis_tready = rdy_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
  end

  // Monitor state.
  int          rd_idx = 0, occ = 0, max_occ = 0;
  int          rd_en_total = 0, tvalid_total = 0, beats_total = 0;
  int          done_cnt = 0, last_done_cyc = 0, busy_rise_cyc = 0;
  int          beat_cyc_q[$];
  logic [15:0] last_rd_ptr = '0;
  bit          prev_stall = 0, prev_busy = 0;
  logic [DW-1:0] prev_data = '0;
  logic        prev_last = 0;
  logic [DW:0] e_mon;

  always @(negedge clk) begin
    if (rst) begin
      rd_idx = 0; occ = 0; prev_stall = 0; prev_busy = 0;
    end else begin
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      prev_busy = busy;
      if (!busy) begin rd_idx = 0; occ = 0; end
      if (busy) chk("credit_le_depth", (occ <= 4), 1);
      if (occ > max_occ) max_occ = occ;
      if (rd_en) begin
        chk("rd_pointer", rd_pointer, rd_idx);
        rd_idx++; rd_en_total++; last_rd_ptr = rd_pointer;
      end
      if (m_axis_tvalid) tvalid_total++;
      if (prev_stall) begin
        chk("stall_tvalid_held", m_axis_tvalid, 1);
        chk("stall_tdata_held", m_axis_tdata, prev_data);
        chk("stall_tlast_held", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=0x%0h required=no_beat", m_axis_tdata);
        end else begin
          e_mon = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, e_mon[DW-1:0]);
          chk("beat_last", m_axis_tlast, e_mon[DW]);
        end
        beats_total++;
        beat_cyc_q.push_back(cyc);
      end
      occ = occ + int'(rd_en) - int'(m_axis_tvalid && m_axis_tready);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (done) begin done_cnt++; last_done_cyc = cyc; end
    end
  end

  int t0 = 0;

  task automatic start_xfer(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    len   = 16'(n);
    t0    = cyc;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem[i]});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > base) begin ok = 1; break; end
    end
    chk("done_within_budget", ok, 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_pointer"}, rd_pointer, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
  endtask

  int bq, r0, v0, d0, b0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    #1 rst = 1'b1;
    #1 chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic burst with exact cycle timing.
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;
    bq = beat_cyc_q.size(); r0 = rd_en_total; d0 = done_cnt;
    start_xfer(4);
    wait_done(d0, 50);
    chk("basic_beats", beat_cyc_q.size() - bq, 4);
    chk("basic_first_beat_cycle", beat_cyc_q[bq] - t0, 3);
    chk("basic_last_beat_cycle", beat_cyc_q[bq + 3] - t0, 6);
    chk("basic_done_cycle", last_done_cyc - t0, 7);
    chk("basic_busy_cycle", busy_rise_cyc - t0, 1);
    chk("basic_rd_en_count", rd_en_total - r0, 4);
    chk("basic_queue_drained", exp_q.size(), 0);

    // Zero length.
    r0 = rd_en_total; v0 = tvalid_total; d0 = done_cnt;
    start_xfer(0);
    wait_done(d0, 20);
    chk("zero_done_cycle", last_done_cyc - t0, 1);
    chk("zero_busy_cycle", busy_rise_cyc - t0, 1);
    chk("zero_idle_cycle2", busy, 0);
    chk("zero_rd_en_count", rd_en_total - r0, 0);
    chk("zero_tvalid_count", tvalid_total - v0, 0);

    // Backpressure with random tready.
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    b0 = beats_total; d0 = done_cnt;
    rdy_mode = 1;
    start_xfer(16);
    wait_done(d0, 1000);
    rdy_mode = 0;
    chk("bp_beats", beats_total - b0, 16);
    chk("bp_fifo_reached_full", max_occ, 4);
    chk("bp_queue_drained", exp_q.size(), 0);

    // Start while busy is ignored.
    b0 = beats_total; d0 = done_cnt;
    start_xfer(5);
    @(posedge clk); #1;
    start = 1'b1; len = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, 100);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_start_done_count", done_cnt - d0, 1);
    chk("busy_start_beats", beats_total - b0, 5);
    chk("busy_start_idle", busy, 0);

    // Start in the DONE cycle is ignored.
    b0 = beats_total; d0 = done_cnt;
    start_xfer(2);
    repeat (4) @(posedge clk);
    #1;
    chk("done_cycle_reached", done, 1);
    start = 1'b1; len = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("done_start_done_count", done_cnt - d0, 1);
    chk("done_start_beats", beats_total - b0, 2);
    chk("done_start_idle", busy, 0);

    // Reset mid-operation.
    b0 = beats_total; d0 = done_cnt;
    start_xfer(8);
    for (int i = 0; i < 100; i++) begin
      if (beats_total - b0 >= 2) break;
      @(posedge clk); #1;
    end
    chk("midreset_two_beats_seen", beats_total - b0, 2);
    rst = 1'b1;
    #1 chk_outputs_zero("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_no_done", done_cnt - d0, 0);
    mem[0] = $urandom; mem[1] = $urandom; mem[2] = $urandom;
    b0 = beats_total; d0 = done_cnt;
    start_xfer(3);
    wait_done(d0, 50);
    chk("post_reset_beats", beats_total - b0, 3);
    chk("post_reset_queue_drained", exp_q.size(), 0);

    // Maximum length.
    b0 = beats_total; bq = beat_cyc_q.size(); d0 = done_cnt;
    start_xfer(65535);
    wait_done(d0, 70000);
    chk("max_beats", beats_total - b0, 65535);
    chk("max_last_pointer", last_rd_ptr, 16'hFFFE);
    chk("max_last_beat_cycle", beat_cyc_q[bq + 65534] - t0, 65537);
    chk("max_done_cycle", last_done_cyc - t0, 65538);
    chk("max_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
